i2c_master_ctrl: RTL
====================

# i2c_master_ctrl

Synthesizable I2C master that performs single-register write and read transactions to the board's I2C peripheral. Sits directly upstream of the peripheral's I2C slave port and drives its `cs`, `sclk` and `sda` pins. Internal logic issues one command per `start` pulse. Read data and ACK status are returned on a one-cycle `done` strobe.

## Interface
- `CLK_DIV`, 250: `clk` cycles per SCL quarter-period (100 MHz → 100 kHz SCL); legal range ≥ 4.
- `SLAVE_ADDR`, 7'h55: 7-bit slave address (wire bytes 8'hAA write, 8'hAB read).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle command request; sampled only in IDLE.
- `rw`  in  1  0 = write, 1 = read; captured with `start`.
- `reg_addr`  in  8  register address; captured with `start`.
- `wr_data`  in  8  write byte; captured with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at end of transaction.
- `ack_err`  out  1  valid with `done`, held until next accepted `start`; 1 = any NACK from slave.
- `rd_data`  out  8  read byte; updated only on a successful read `done`.
- `cs`  out  1  slave enable; high for whole transaction.
- `sclk`  out  1  I2C clock, push-pull.
- `sda`  inout  1  open-drain: driven 0 or released (z); external pull-up.

## Operation
- Quarter tick: a counter wraps at `CLK_DIV-1`. Every bit cell is 4 ticks:
  - Q0 and Q1: SCL low.
  - Q2 and Q3: SCL high.
  - SDA changes only at Q0 entry.
  - SDA is sampled on the last `clk` of Q3.
- States: IDLE, START, ADDR_W, ACK_A, REG, ACK_R, WDATA, ACK_D, RSTART, ADDR_R, ACK_AR, RDATA, MNACK, STOP, FIN.
- Write sequence: START → ADDR_W(8'hAA) → ACK_A → REG → ACK_R → WDATA → ACK_D → STOP → FIN.
- Read sequence: START → ADDR_W → ACK_A → REG → ACK_R → RSTART → ADDR_R(8'hAB) → ACK_AR → RDATA → MNACK (SDA released, i.e. NACK) → STOP → FIN.
- Bytes are sent MSB first. A 3-bit counter runs 7→0. Leaving the byte state occurs after bit 0's Q3.
- START bus conditions:
  - `cs` rises at START entry.
  - SCL and SDA are high for 2 ticks, then SDA falls while SCL is high.
  - SCL falls 2 ticks later.
- RSTART: release SDA with SCL low; raise SCL; then pull SDA low while SCL is high (same tick spacing as START).
- STOP:
  - SDA low with SCL low.
  - SCL rises.
  - After 2 ticks, SDA is released while SCL is high.
  - `cs` falls 2 ticks after the SDA release.
- ACK states release SDA. A sampled 1 is a NACK: set the error flag and go directly to STOP (remaining bytes are skipped).
- FIN: `done`=1 for one cycle; `busy`=0 the same cycle; then IDLE.
- `start` while `busy` is ignored, with no queueing.
- Reset values: `busy`=0, `done`=0, `ack_err`=0, `rd_data`=8'h00, `cs`=0, `sclk`=1, `sda` released, state IDLE, counters 0.

## Timing
- Accepted `start` (IDLE, `start`=1) → `busy`=1 next cycle; first SCL fall is 4 ticks later.
- Write: 9 bit cells per byte × 3 bytes, plus START and STOP (1 cell each) = 29 cells. `done` follows STOP completion by 1 cycle.
- Read: 9×4 byte cells + START + RSTART + STOP = 39 cells.
- Slave-driven SDA must be valid within 2 ticks of SCL falling. At default `CLK_DIV` this is 5 µs; the slave changes SDA 3 µs after SCL falls.
- Reset mid-transaction: on the next edge all outputs return to reset values. The bus is left with `cs`=0 and SCL/SDA high, and no STOP is generated.
- `rd_data` changes only in the FIN cycle of an error-free read.

## Configuration
- `I2C_MASTER_ACK_CHECK_EN` defined: behaviour as above.
  - NACK aborts to STOP.
  - `ack_err` reports it.
- Not defined: ACK slots are still clocked with SDA released, but not evaluated.
  - The sequence always completes.
  - `ack_err` is constant 0.

## Test plan
- Write `reg_addr`=8'h12, `wr_data`=8'h5A → bus bytes AA, 12, 5A, all ACKed; STOP seen; `done` pulse; `ack_err`=0; 29 bit cells.
- Read `reg_addr`=8'h34, slave returns 8'hC3 → bus AA, 34, repeated START, AB; master NACK then STOP; `rd_data`=8'hC3; `ack_err`=0.
- `SLAVE_ADDR`=7'h50, slave responds only to 0x55 → NACK on first ACK; immediate STOP; `ack_err`=1; `rd_data` unchanged (8'h00).
- Pulse `start` again mid-write → ignored; exactly one transaction and one `done`.
- Assert `rst` during REG bit 4 → next edge `cs`=0, `sclk`=1, SDA released, `busy`=0; a subsequent write completes normally.
- Build without `I2C_MASTER_ACK_CHECK_EN`, wrong address → full 29-cell write completes; `ack_err`=0.

Source files
------------

// File: rtl/i2c_master_ctrl_if.sv
// i2c_master_ctrl_if: command/status handshake between host logic and the I2C master
interface i2c_master_ctrl_if;
    logic       start;
    logic       rw;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rd_data;
    modport master (input start, rw, reg_addr, wr_data, output busy, done, ack_err, rd_data);
    modport slave (output start, rw, reg_addr, wr_data, input busy, done, ack_err, rd_data);
endinterface

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-register I2C write/read master; define I2C_MASTER_ACK_CHECK_EN to evaluate slave ACKs
module i2c_master_ctrl #(
    parameter int         CLK_DIV    = 250,
    parameter logic [6:0] SLAVE_ADDR = 7'h55
) (
    input  logic         clk,
    input  logic         rst,
    i2c_master_ctrl_if.master host,
    output logic         cs,
    output logic         sclk,
    inout  wire          sda
);
    localparam int CW = $clog2(CLK_DIV);
    typedef enum logic [3:0] {
        IDLE, START, ADDR_W, ACK_A, REG, ACK_R, WDATA, ACK_D,
        RSTART, ADDR_R, ACK_AR, RDATA, MNACK, STOP, FIN
    } state_t;
    state_t        st, nst;
    logic [CW-1:0] cnt;
    logic [1:0]    q, nq;
    logic [2:0]    bitn, nbit;
    logic          rw_r, sda_oe, scl_n, oe_n, tick, cell_end, nack, is_byte;
    logic [7:0]    reg_r, wd_r, shreg, tx;
    assign sda      = sda_oe ? 1'b0 : 1'bz;
    assign tick     = cnt == CW'(CLK_DIV - 1);
    assign cell_end = tick && q == 2'd3;
    assign nq       = q + 2'd1;
`ifdef I2C_MASTER_ACK_CHECK_EN
    assign nack = sda;
`else
    assign nack = 1'b0;
`endif
    // sequencing of bit cells; a NACK in any ACK slot jumps straight to STOP
    always_comb begin
        nst = st;
        if (cell_end)
            case (st)
                START:   nst = ADDR_W;
                ADDR_W:  nst = bitn == 3'd0 ? ACK_A : ADDR_W;
                ACK_A:   nst = nack ? STOP : REG;
                REG:     nst = bitn == 3'd0 ? ACK_R : REG;
                ACK_R:   nst = nack ? STOP : rw_r ? RSTART : WDATA;
                WDATA:   nst = bitn == 3'd0 ? ACK_D : WDATA;
                ACK_D:   nst = STOP;
                RSTART:  nst = ADDR_R;
                ADDR_R:  nst = bitn == 3'd0 ? ACK_AR : ADDR_R;
                ACK_AR:  nst = nack ? STOP : RDATA;
                RDATA:   nst = bitn == 3'd0 ? MNACK : RDATA;
                MNACK:   nst = STOP;
                STOP:    nst = FIN;
                default: nst = st;
            endcase
    end
    // pin levels for the quarter being entered, so the outputs can be registered
    always_comb begin
        is_byte = st inside {ADDR_W, REG, WDATA, ADDR_R, RDATA};
        nbit    = (cell_end && is_byte) ? bitn - 3'd1 : bitn;
        tx      = nst == ADDR_W ? {SLAVE_ADDR, 1'b0} : nst == REG ? reg_r :
                  nst == WDATA ? wd_r : nst == ADDR_R ? {SLAVE_ADDR, 1'b1} : 8'hFF;
        scl_n   = (nst == START || nst == FIN) ? 1'b1 :
                  (nst == RSTART || nst == STOP) ? (nq != 2'd0) : nq[1];
        oe_n    = (nst == START || nst == RSTART) ? nq[1] : nst == STOP ? ~nq[1] : ~tx[nbit];
    end
    // transaction FSM with registered bus pins and status
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            cnt <= '0;
            q <= 2'd0;
            bitn <= 3'd0;
            busy_clr();
        end else if (st == IDLE) begin
            host.done <= 1'b0;
            if (host.start) begin
                st <= START;
                cnt <= '0;
                q <= 2'd0;
                bitn <= 3'd7;
                rw_r <= host.rw;
                reg_r <= host.reg_addr;
                wd_r <= host.wr_data;
                host.busy <= 1'b1;
                host.ack_err <= 1'b0;
                cs <= 1'b1;
                sclk <= 1'b1;
                sda_oe <= 1'b0;
            end
        end else if (st == FIN) begin
            st <= IDLE;
            host.done <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                q <= nq;
                st <= nst;
                bitn <= nbit;
                sclk <= scl_n;
                sda_oe <= oe_n;
            end
            if (cell_end && st == RDATA)
                shreg <= {shreg[6:0], sda};
            if (cell_end && nack && st inside {ACK_A, ACK_R, ACK_D, ACK_AR})
                host.ack_err <= 1'b1;
            if (nst == FIN) begin
                host.done <= 1'b1;
                host.busy <= 1'b0;
                cs <= 1'b0;
                if (rw_r && !host.ack_err)
                    host.rd_data <= shreg;
            end
        end
    end
    task automatic busy_clr();
        host.busy <= 1'b0;
        host.done <= 1'b0;
        host.ack_err <= 1'b0;
        host.rd_data <= 8'h00;
        cs <= 1'b0;
        sclk <= 1'b1;
        sda_oe <= 1'b0;
        rw_r <= 1'b0;
        reg_r <= 8'h00;
        wd_r <= 8'h00;
        shreg <= 8'h00;
    endtask
endmodule
